data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- BUS_AW, 32, address width.
- BUS_DW, 32, data width.
- BUS_DBW, 4, byte-enable width (BUS_DW/8).
- MEM_DEPTH, 256, memory words (power of 2).
- GNT_DELAY, 0, cycles req is held before gnt (0..3).
- RSP_LATENCY, 1, cycles from accept to rvalid (1..4).
- MAX_OUTSTANDING, 2, accepted-but-unresponded cap (1..RSP_LATENCY+1).

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk  input  1  clock; one clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_req_o  input  1  LSU request.
- data_addr_o  input  BUS_AW  byte address.
- data_we_o  input  1  1=write, 0=read.
- data_be_o  input  BUS_DBW  byte enables.
- data_wdata_o  input  BUS_DW  write data.
- data_gnt_i  output  1  grant to LSU.
- data_rvalid_i  output  1  response valid, one cycle per accepted request.
- data_rdata_i  output  BUS_DW  read data, registered.

Function
REQ-003 Acceptance SHALL occur in a cycle where data_req_o=1 and data_gnt_i=1; at most one acceptance per cycle.
REQ-004 A wait counter SHALL count consecutive cycles with data_req_o=1 and no acceptance; it clears on acceptance or when data_req_o=0.
REQ-005 data_gnt_i SHALL be combinational: data_req_o=1, wait counter >= GNT_DELAY, and outstanding slot available (REQ-008). With GNT_DELAY=0, gnt is asserted in the same cycle as req.
REQ-006 Word index SHALL be data_addr_o[log2(MEM_DEPTH)+1:2]; data_addr_o[1:0] SHALL be ignored.
REQ-007 An address is out of range if data_addr_o>>2 >= MEM_DEPTH. Out-of-range writes SHALL be dropped. Out-of-range reads SHALL return 32'hDEAD_BEEF. Either case still gets a response.
REQ-008 The outstanding counter SHALL increment on acceptance and decrement on each rvalid cycle. Simultaneous increment and decrement SHALL leave it unchanged. A slot is available if the count < MAX_OUTSTANDING, or if the count = MAX_OUTSTANDING and rvalid is asserted this cycle.
REQ-009 An accepted write SHALL update memory at the accept edge, only in bytes whose data_be_o bit is 1. Its response SHALL carry data_rdata_i=0.
REQ-010 An accepted read SHALL sample the memory word at the accept edge. A write accepted in cycle N SHALL be visible to a read accepted in cycle N+1 or later.
REQ-011 Responses SHALL travel a RSP_LATENCY-stage pipeline. data_rvalid_i and data_rdata_i SHALL assert exactly RSP_LATENCY cycles after the accept edge, in acceptance order, with no backpressure.
REQ-012 When data_rvalid_i=0, data_rdata_i SHALL hold 0.
REQ-013 The input fields SHALL be sampled only at acceptance; changes while waiting for gnt SHALL be used as presented in the accept cycle.
REQ-014 Counter overflow SHALL be impossible: the outstanding counter and wait counter SHALL be saturating, with width ceil(log2(MAX+1)).

Reset
REQ-015 While rst=1, asynchronously: data_gnt_i=0, data_rvalid_i=0, data_rdata_i=0, wait counter=0, outstanding=0, pipeline valids cleared.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 Responses in flight at reset assertion SHALL be discarded and never produced.
REQ-018 After rst deasserts, the first acceptance SHALL be possible at the first rising edge with rst=0.

Verification
REQ-019 Write then read: GNT_DELAY=0, RSP_LATENCY=1.
- Stimulus: write addr 0x10, be 4'hF, wdata 0xA5A5_1234; next cycle read addr 0x10.
- Required: gnt in both req cycles; rvalid in cycles 2 and 3; rdata 0 then 0xA5A5_1234.
REQ-020 Partial byte write:
- Stimulus: preload word 4 with 0x1122_3344; write be 4'b0101, wdata 0xFFFF_FFFF; then read.
- Required: read returns 0x11FF_33FF.
REQ-021 Grant delay: GNT_DELAY=2.
- Stimulus: req held from cycle 0.
- Required: gnt low in cycles 0-1, high in cycle 2; with RSP_LATENCY=1, rvalid in cycle 3.
REQ-022 Outstanding cap: MAX_OUTSTANDING=2, RSP_LATENCY=4.
- Stimulus: continuous reads.
- Required: accepts in cycles 0 and 1; gnt low in cycles 2-3; gnt high again in cycle 4, the cycle of the first rvalid; responses in order.
REQ-023 Out-of-range address: MEM_DEPTH=256.
- Stimulus: write then read at addr 0x400.
- Required: memory unchanged; read rdata 0xDEAD_BEEF; both requests get rvalid.
REQ-024 Reset mid-operation: RSP_LATENCY=3.
- Stimulus: read accepted in cycle 0; rst pulse in cycle 1.
- Required: no rvalid in cycles 1-5; outstanding=0; a subsequent read of a previously written word still returns the pre-reset data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data memory answering LSU requests with a fixed-latency, in-order response pipeline.
// Grant is combinational, gated by a programmable wait and an outstanding-response cap.
module data_mem_responder #(
    parameter int BUS_AW          = 32,
    parameter int BUS_DW          = 32,
    parameter int BUS_DBW         = 4,
    parameter int MEM_DEPTH       = 256,
    parameter int GNT_DELAY       = 0,
    parameter int RSP_LATENCY     = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req_o,
    input  logic [BUS_AW-1:0] data_addr_o,
    input  logic              data_we_o,
    input  logic [BUS_DBW-1:0] data_be_o,
    input  logic [BUS_DW-1:0] data_wdata_o,
    output logic              data_gnt_i,
    output logic              data_rvalid_i,
    output logic [BUS_DW-1:0] data_rdata_i
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WAIT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic [BUS_DW-1:0]      mem [MEM_DEPTH];
    logic [OUT_W-1:0]       outstanding;
    logic [RSP_LATENCY-1:0] pipe_vld;
    logic [BUS_DW-1:0]      pipe_dat [RSP_LATENCY];
    logic                   wait_ok;
    logic                   slot_ok;
    logic                   accept;
    logic                   out_of_range;
    logic [IDX_W-1:0]       word_idx;
    logic [BUS_AW-1:0]      word_addr;
    logic [BUS_DW-1:0]      rsp_dat;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = ^data_addr_o[1:0];
    assign word_addr       = data_addr_o >> 2;
    assign out_of_range    = word_addr >= BUS_AW'(MEM_DEPTH);
    assign word_idx        = data_addr_o[IDX_W+1:2];

    generate
        if (GNT_DELAY == 0) begin : g_no_wait
            assign wait_ok = 1'b1;
        end else begin : g_wait
            logic [WAIT_W-1:0] wait_cnt;

            // Counts consecutive un-granted request cycles, saturating at the delay.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wait_cnt <= '0;
                end else if (!data_req_o || accept) begin
                    wait_cnt <= '0;
                end else if (wait_cnt < WAIT_W'(GNT_DELAY)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end

            assign wait_ok = wait_cnt >= WAIT_W'(GNT_DELAY);
        end
    endgenerate

    // A full tracker still frees a slot in the cycle a response retires.
    assign slot_ok = (outstanding < OUT_W'(MAX_OUTSTANDING)) ||
                     ((outstanding == OUT_W'(MAX_OUTSTANDING)) && data_rvalid_i);

    assign data_gnt_i = !rst && data_req_o && wait_ok && slot_ok;
    assign accept     = data_gnt_i;

    always_comb begin
        rsp_dat = '0;
        if (!data_we_o) begin
            if (out_of_range) begin
                rsp_dat = BUS_DW'(32'hDEAD_BEEF);
            end else begin
                rsp_dat = mem[word_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (accept && !data_rvalid_i) begin
            if (outstanding != OUT_W'(MAX_OUTSTANDING)) begin
                outstanding <= outstanding + OUT_W'(1);
            end
        end else if (!accept && data_rvalid_i) begin
            if (outstanding != '0) begin
                outstanding <= outstanding - OUT_W'(1);
            end
        end
    end

    // Stage data is zero whenever its valid is low, so the output rests at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_dat[0] <= accept ? rsp_dat : '0;
            for (int i = 1; i < RSP_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && data_we_o && !out_of_range) begin
            for (int b = 0; b < BUS_DBW; b++) begin
                if (data_be_o[b]) begin
                    mem[word_idx][b*8 +: 8] <= data_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    assign data_rvalid_i = pipe_vld[RSP_LATENCY-1];
    assign data_rdata_i  = pipe_dat[RSP_LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: four responder instances with different grant/latency settings, one active at a time.
module tb_data_mem_responder;
    localparam int N = 4;
    localparam int GD  [N] = '{0, 2, 0, 0};
    localparam int LAT [N] = '{1, 1, 4, 3};

    typedef struct {
        int          inst;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [N];
    logic [31:0] addr   [N];
    logic        we     [N];
    logic [3:0]  be     [N];
    logic [31:0] wdata  [N];
    logic        gnt    [N];
    logic        rvalid [N];
    logic [31:0] rdata  [N];

    exp_t sbq [$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < N; k++) begin : g_dut
        data_mem_responder #(
            .BUS_AW(32), .BUS_DW(32), .BUS_DBW(4), .MEM_DEPTH(256),
            .GNT_DELAY(GD[k]), .RSP_LATENCY(LAT[k]), .MAX_OUTSTANDING(2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .data_req_o   (req[k]),
            .data_addr_o  (addr[k]),
            .data_we_o    (we[k]),
            .data_be_o    (be[k]),
            .data_wdata_o (wdata[k]),
            .data_gnt_i   (gnt[k]),
            .data_rvalid_i(rvalid[k]),
            .data_rdata_i (rdata[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds a request until granted; records the expected response at the accept cycle.
    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] exp_d, input logic push,
                         output int waits);
        exp_t e;
        bit   done;
        waits = 0;
        done  = 0;
        req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (gnt[k]) begin
                done = 1;
                if (push) begin
                    e.inst = k;
                    e.dat  = exp_d;
                    e.cyc  = cyc + LAT[k];
                    sbq.push_back(e);
                end
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        req[k] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: inst %0d got no grant, required grant within 20 cycles", k);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (rvalid[k]) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid: inst %0d cycle %0d rdata %h, required no response", k, cyc, rdata[k]);
                end else begin
                    e = sbq.pop_front();
                    if (e.inst != k || e.dat !== rdata[k] || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL response: got inst %0d data %h cycle %0d, required inst %0d data %h cycle %0d",
                                 k, rdata[k], cyc, e.inst, e.dat, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (rdata[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_rdata: inst %0d got %h required 00000000", k, rdata[k]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b1; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("reset_gnt", 32'(gnt[k]), 32'h0);
            chk("reset_rvalid", 32'(rvalid[k]), 32'h0);
            req[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write then read, zero grant delay, latency 1
        issue(0, 1'b1, 32'h10, 4'hF, 32'hA5A5_1234, 32'h0, 1'b1, w);
        chk("wr_waits", 32'(w), 32'd0);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hA5A5_1234, 1'b1, w);
        chk("rd_waits", 32'(w), 32'd0);
        drain(4);

        // Partial byte write; low address bits ignored on the final read
        issue(0, 1'b1, 32'h10, 4'hF, 32'h1122_3344, 32'h0, 1'b1, w);
        issue(0, 1'b1, 32'h10, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b1, w);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'h11FF_33FF, 1'b1, w);
        issue(0, 1'b0, 32'h13, 4'hF, 32'h0, 32'h11FF_33FF, 1'b1, w);
        drain(4);

        // Out-of-range write must not alias onto word 0; top in-range word works
        issue(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b1, w);
        issue(0, 1'b1, 32'h400, 4'hF, 32'h5555_5555, 32'h0, 1'b1, w);
        issue(0, 1'b0, 32'h400, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1, w);
        issue(0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b1, w);
        issue(0, 1'b1, 32'h3FC, 4'hF, 32'h1357_9BDF, 32'h0, 1'b1, w);
        issue(0, 1'b0, 32'h3FC, 4'hF, 32'h0, 32'h1357_9BDF, 1'b1, w);
        drain(4);

        // Grant delay of two cycles
        issue(1, 1'b1, 32'h8, 4'hF, 32'h0000_0042, 32'h0, 1'b1, w);
        chk("gdly_wr_waits", 32'(w), 32'd2);
        issue(1, 1'b0, 32'h8, 4'hF, 32'h0, 32'h0000_0042, 1'b1, w);
        chk("gdly_rd_waits", 32'(w), 32'd2);
        drain(4);

        // Outstanding cap with latency 4
        issue(2, 1'b1, 32'h0, 4'hF, 32'h1111_0000, 32'h0, 1'b1, w);
        issue(2, 1'b1, 32'h4, 4'hF, 32'h2222_0000, 32'h0, 1'b1, w);
        issue(2, 1'b1, 32'h8, 4'hF, 32'h3333_0000, 32'h0, 1'b1, w);
        drain(8);
        issue(2, 1'b0, 32'h0, 4'hF, 32'h0, 32'h1111_0000, 1'b1, w);
        chk("cap_rd0_waits", 32'(w), 32'd0);
        issue(2, 1'b0, 32'h4, 4'hF, 32'h0, 32'h2222_0000, 1'b1, w);
        chk("cap_rd1_waits", 32'(w), 32'd0);
        issue(2, 1'b0, 32'h8, 4'hF, 32'h0, 32'h3333_0000, 1'b1, w);
        chk("cap_rd2_waits", 32'(w), 32'd2);
        issue(2, 1'b0, 32'h0, 4'hF, 32'h0, 32'h1111_0000, 1'b1, w);
        chk("cap_rd3_waits", 32'(w), 32'd0);
        drain(8);

        // Reset mid-operation with latency 3: in-flight read is discarded
        issue(3, 1'b1, 32'h20, 4'hF, 32'hCAFE_0001, 32'h0, 1'b1, w);
        drain(5);
        issue(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 1'b0, w);
        rst = 1'b1;
        req[3] = 1'b1;
        @(negedge clk);
        chk("rst_mid_gnt", 32'(gnt[3]), 32'h0);
        chk("rst_c1_rvalid", 32'(rvalid[3]), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req[3] = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk("rst_quiet_rvalid", 32'(rvalid[3]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req[3] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFE_0001, 1'b1, w);
        chk("post_rst_waits", 32'(w), 32'd0);
        drain(5);
        issue(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFE_0001, 1'b1, w);
        chk("post_rst_rd0_waits", 32'(w), 32'd0);
        issue(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFE_0001, 1'b1, w);
        chk("post_rst_rd1_waits", 32'(w), 32'd0);
        issue(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFE_0001, 1'b1, w);
        chk("post_rst_rd2_waits", 32'(w), 32'd1);
        drain(8);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
